// File: rtl/uart_beacon_echo.sv
// UART application layer: periodic beacon message plus FIFO-buffered echo of
// received bytes, with optional CR -> CR LF expansion on the echo path.
//
// state   | meaning
// IDLE    | nothing offered; picks beacon first, then a buffered echo byte
// BEACON  | streaming message bytes 0..MSG_LEN-1 to uart_tx
// ECHO    | offering the FIFO head; popped on transfer
// ECHO_LF | offering the LF that follows an echoed CR
module uart_beacon_echo #(
    parameter int                   MSG_LEN    = 15,
    parameter logic [MSG_LEN*8-1:0] MSG        = {"HELLO GOWIN 01", 8'h0a},
    parameter int                   PERIOD_CYC = 27_000_000,
    parameter int                   FIFO_DEPTH = 16,
    parameter bit                   CR_EXPAND  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_data_valid,
    output logic        rx_data_ready,
    output logic [7:0]  tx_data,
    output logic        tx_data_valid,
    input  logic        tx_data_ready,
    input  logic        beacon_en,
    output logic [15:0] overflow_cnt,
    output logic        busy
);

    localparam int              AW        = $clog2(FIFO_DEPTH);
    localparam int              CW        = $clog2(PERIOD_CYC);
    localparam logic [CW-1:0]   CNT_LAST  = CW'(PERIOD_CYC - 1);
    localparam logic [7:0]      IDX_LAST  = 8'(MSG_LEN - 1);
    localparam logic [AW:0]     FIFO_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, BEACON, ECHO, ECHO_LF} state_t;

    state_t        state_q, state_d;
    logic [7:0]    tx_data_d;
    logic          tx_valid_d;
    logic [7:0]    msg_idx, msg_idx_d;
    logic          xfer, push, pop, take_beacon;

    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;

    logic [CW-1:0] period_cnt;
    logic          beacon_pending;
    logic          period_wrap;

    // Byte idx of the message, counting from the most significant byte.
    function automatic logic [7:0] msg_byte(input logic [7:0] idx);
        logic [MSG_LEN*8-1:0] sh;
        sh = MSG << {idx, 3'b000};
        return sh[MSG_LEN*8-1 -: 8];
    endfunction

    assign rx_data_ready = (fifo_cnt != FIFO_FULL);
    assign push          = rx_data_valid && rx_data_ready;
    assign xfer          = tx_data_valid && tx_data_ready;
    assign busy          = (state_q != IDLE);
    assign period_wrap   = (period_cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            overflow_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
            if (rx_data_valid && !rx_data_ready && (overflow_cnt != 16'hFFFF)) begin
                overflow_cnt <= overflow_cnt + 1'b1;
            end
        end
    end

    // A wrap coinciding with the IDLE pickup is a fresh request, so set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_cnt     <= '0;
            beacon_pending <= 1'b1;
        end else if (!beacon_en) begin
            period_cnt     <= '0;
            beacon_pending <= 1'b0;
        end else begin
            period_cnt <= period_wrap ? '0 : period_cnt + 1'b1;
            if (period_wrap) begin
                beacon_pending <= 1'b1;
            end else if (take_beacon) begin
                beacon_pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tx_data       <= '0;
            tx_data_valid <= 1'b0;
            msg_idx       <= '0;
        end else begin
            state_q       <= state_d;
            tx_data       <= tx_data_d;
            tx_data_valid <= tx_valid_d;
            msg_idx       <= msg_idx_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        tx_data_d   = tx_data;
        tx_valid_d  = tx_data_valid;
        msg_idx_d   = msg_idx;
        pop         = 1'b0;
        take_beacon = 1'b0;
        case (state_q)
            IDLE: begin
                if (beacon_pending && beacon_en) begin
                    take_beacon = 1'b1;
                    msg_idx_d   = '0;
                    tx_data_d   = msg_byte(8'd0);
                    tx_valid_d  = 1'b1;
                    state_d     = BEACON;
                end else if (fifo_cnt != '0) begin
                    tx_data_d  = fifo_mem[rd_ptr];
                    tx_valid_d = 1'b1;
                    state_d    = ECHO;
                end else begin
                    tx_valid_d = 1'b0;
                end
            end
            BEACON: begin
                if (xfer) begin
                    if (msg_idx == IDX_LAST) begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end else begin
                        msg_idx_d = msg_idx + 8'd1;
                        tx_data_d = msg_byte(msg_idx + 8'd1);
                    end
                end
            end
            ECHO: begin
                // One byte per visit lets a pending beacon in between echoes.
                if (xfer) begin
                    pop = 1'b1;
                    if (CR_EXPAND && (tx_data == 8'h0D)) begin
                        tx_data_d = 8'h0A;
                        state_d   = ECHO_LF;
                    end else begin
                        tx_valid_d = 1'b0;
                        state_d    = IDLE;
                    end
                end
            end
            ECHO_LF: begin
                if (xfer) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                tx_valid_d = 1'b0;
                state_d    = IDLE;
            end
        endcase
    end

endmodule

// File: doc/uart_beacon_echo.md
Name: uart_beacon_echo

Overview:
Parametrised UART application layer that sits between the existing uart_rx and uart_tx byte interfaces.
- Periodically transmits a fixed message (beacon) of configurable length and period.
- Echoes every received byte through a FIFO, so bytes arriving during a beacon are not lost.
- Optionally expands echoed CR (0x0D) to CR LF.
- Reports overflow drops and busy status.

Parameters:
MSG_LEN, 15, beacon length in bytes (1..255)
MSG, {"HELLO GOWIN 01",8'h0a}, beacon content, MSG_LEN*8 bits; the first byte sent is MSG[MSG_LEN*8-1 -: 8]
PERIOD_CYC, 27_000_000, clk cycles between beacon requests (>=2)
FIFO_DEPTH, 16, echo FIFO depth in bytes; power of 2, >=2
CR_EXPAND, 1, 1 = echoed 0x0D is followed by 0x0A

Ports:
clk  in  1  system clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
rx_data  in  8  byte from uart_rx
rx_data_valid  in  1  single-cycle strobe from uart_rx; the byte is not held
rx_data_ready  out  1  1 when FIFO count < FIFO_DEPTH
tx_data  out  8  byte to uart_tx
tx_data_valid  out  1  byte offered
tx_data_ready  in  1  uart_tx accepts
beacon_en  in  1  1 = periodic beacon enabled
overflow_cnt  out  16  count of received bytes dropped on FIFO full; saturates at 0xFFFF
busy  out  1  1 when state != IDLE

Behaviour:
Reset values:
- tx_data=0, tx_data_valid=0, overflow_cnt=0, busy=0.
- FIFO empty, so rx_data_ready=1.
- Period counter=0, beacon_pending=1, state=IDLE.
- Reset asserted mid-transfer aborts immediately; no partial-byte recovery.

Handshake:
- A tx transfer occurs on a clk edge with tx_data_valid && tx_data_ready.
- Once valid is raised, tx_data is stable and valid stays high until the transfer completes.
- Valid may stay high across back-to-back bytes; no idle cycle is required between bytes.

RX / FIFO:
- A write occurs when rx_data_valid && rx_data_ready.
- rx_data_valid while full: byte dropped, overflow_cnt += 1 (saturating).
- rx_data_ready derives from count only. When full, a write is rejected even if a pop happens in the same cycle.
- Simultaneous push and pop with count in 1..DEPTH-1: count unchanged.
- Pointers are log2(DEPTH) bits and wrap naturally.

Period counter:
- When beacon_en=0: counter held at 0 and beacon_pending cleared.
- When beacon_en=1: counter increments; at PERIOD_CYC-1 it wraps to 0 and sets beacon_pending.
- A new request while already pending is coalesced (a single pending flag, no queueing).

State machine (IDLE, BEACON, ECHO, ECHO_LF):
- IDLE, priority order:
  - beacon_pending && beacon_en -> BEACON: clear pending, msg index=0, drive first message byte with valid=1 on the next cycle.
  - Otherwise FIFO non-empty -> ECHO: drive FIFO head with valid=1 on the next cycle.
  - Otherwise stay in IDLE with valid=0.
- BEACON:
  - On each transfer the index increments and the next byte is presented in the following cycle.
  - On the transfer of byte MSG_LEN-1: valid=0, go to IDLE.
  - Deasserting beacon_en mid-message does not abort the message.
  - The FIFO keeps accepting bytes throughout.
- ECHO:
  - On transfer, pop the FIFO.
  - If CR_EXPAND && byte==0x0D -> ECHO_LF with tx_data=0x0A, valid=1.
  - Otherwise valid=0, go to IDLE.
  - Exactly one byte is echoed per ECHO entry, so a pending beacon preempts between echo bytes.
- ECHO_LF: on transfer, valid=0, go to IDLE.
- Latency: from rx write into an empty FIFO (state IDLE, no beacon pending) to tx_data_valid=1 is 2 clk.
- Echoed bytes are never reordered or duplicated. The beacon is never interleaved inside a CR/LF pair.

Test Plan:
- Reset, beacon_en=1, MSG_LEN=3, MSG="ABC", PERIOD_CYC=200, tx_data_ready=1 -> 0x41,0x42,0x43 sent on consecutive transfers right after reset; next beacon 200 cycles after reset release; busy=1 only during sends.
- beacon_en=0, tx_data_ready=1, rx bytes 0x31 then 0x0D -> tx sequence 0x31,0x0D,0x0A; with CR_EXPAND=0 -> 0x31,0x0D only.
- Hold tx_data_ready=0, push 18 bytes into a depth-16 FIFO -> rx_data_ready=0 after 16, overflow_cnt=2; release ready -> the first 16 bytes are echoed in order.
- Beacon pending and 3 rx bytes arrive mid-beacon -> the full beacon completes uninterrupted, then the 3 bytes are echoed; an rx 0x0D echoed just before a beacon is due is followed by 0x0A before the beacon's first byte.
- tx_data_ready toggling randomly -> tx_data stable while valid && !ready; no byte lost or duplicated versus the reference model.
- Assert rst_n=0 mid-beacon with the FIFO holding 5 bytes -> all outputs return to reset values asynchronously, FIFO empty, beacon restarts from byte 0 after release.
